mdu_ctrl: RTL

// - Sequences the multi-cycle multiply/divide unit (MDU) in the E stage of the 5-stage MIPS pipeline.
// - Accepts mult/multu/div/divu/mthi/mtlo from E and holds the HI/LO registers.
// - Raises Busy for a fixed latency per operation.
// - The hazard unit uses Start|Busy to stall any D-stage MD instruction (mult/div/mfhi/mflo/mthi/mtlo).

---
 rtl/mdu_ctrl_pkg.sv | 31 +++
 rtl/mdu_arith.sv | 79 +++++++
 rtl/mdu_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation encoding,
// sequencer states, default latencies and operation-class helpers.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator: 64-bit product, or quotient (lo) and
// remainder (hi); wr is low when the operation must not update HI/LO.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] sdividend;
  logic signed [31:0] sdivisor;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] udivisor;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign sa64   = {{32{a[31]}}, a};
  assign sb64   = {{32{b[31]}}, b};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Zero and overflow divisors are replaced by 1 so the dividers never see
  // an undefined case; the real results for those cases are selected below.
  assign div_zero  = (b == 32'd0);
  assign div_ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sdividend = a;
  assign sdivisor  = (div_zero || div_ovf) ? 32'sd1 : b;
  assign quo_s     = sdividend / sdivisor;
  assign rem_s     = sdividend % sdivisor;
  assign udivisor  = div_zero ? 32'd1 : b;
  assign quo_u     = a / udivisor;
  assign rem_u     = a % udivisor;

  always_comb begin
    hi = '0;
    lo = '0;
    wr = 1'b0;
    case (op)
      MD_MULT: begin
        {hi, lo} = prod_s;
        wr       = 1'b1;
      end
      MD_MULTU: begin
        {hi, lo} = prod_u;
        wr       = 1'b1;
      end
      MD_DIV: begin
        wr = !div_zero;
        if (div_ovf) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          lo = quo_s;
          hi = rem_s;
        end
      end
      MD_DIVU: begin
        wr = !div_zero;
        lo = quo_u;
        hi = rem_u;
      end
      default: begin
        wr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: accepts MD ops, holds Busy for a fixed
// latency, and owns the architectural HI/LO registers.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;

  logic [31:0]        pend_hi_p1;
  logic [31:0]        pend_lo_p1;
  logic               pend_vld_p1;

  logic               accept;
  logic               commit;
  logic               mthi_we;
  logic               mtlo_we;

  mdu_arith u_arith (
    .op (MDOp),
    .a  (A),
    .b  (B),
    .hi (res_hi),
    .lo (res_lo),
    .wr (res_wr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (Start && is_mult_op(MDOp)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_W'(MULT_LAT);
        end else if (Start && is_div_op(MDOp)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_W'(DIV_LAT);
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    Busy    = (state == ST_RUN);
    accept  = (state == ST_IDLE) && Start && (is_mult_op(MDOp) || is_div_op(MDOp));
    commit  = (state == ST_RUN) && (cnt == CNT_W'(1)) && pend_vld_p1;
    mthi_we = (state == ST_IDLE) && Start && (MDOp == MD_MTHI);
    mtlo_we = (state == ST_IDLE) && Start && (MDOp == MD_MTLO);
  end

  // p1: operands' result captured at accept, held until the final busy edge
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_hi_p1  <= res_hi;
      pend_lo_p1  <= res_lo;
      pend_vld_p1 <= res_wr;
    end
  end

  // Architectural HI/LO: completion writeback or direct mthi/mtlo
  always_ff @(posedge clk) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      HI <= pend_hi_p1;
      LO <= pend_lo_p1;
    end else begin
      if (mthi_we) HI <= A;
      if (mtlo_we) LO <= A;
    end
  end

endmodule
